// File: rtl/ram_mem_pkg.sv
// Shared defaults and word type for the single-port RAM.
package ram_mem_pkg;

  localparam int unsigned RAM_W = 32;
  localparam int unsigned RAM_L = 16;

  typedef logic [RAM_W-1:0] word_t;

endpackage : ram_mem_pkg

// File: rtl/ram_mem_if.sv
// Address/data/control bundle between a RAM owner (master) and the RAM (slave).
interface ram_mem_if
  import ram_mem_pkg::*;
#(
  parameter int unsigned W = RAM_W,
  parameter int unsigned L = RAM_L
) ();

  localparam int unsigned AW = $clog2(L);

  logic [AW-1:0] addr;
  logic [W-1:0]  data_in;
  logic          rw;
  logic          oe;
  logic [W-1:0]  data_out;

  modport master (output addr, output data_in, output rw, output oe, input data_out);
  modport slave  (input addr, input data_in, input rw, input oe, output data_out);

endinterface : ram_mem_if

// File: rtl/ram_mem.sv
// Single-port word-addressed RAM: synchronous write, combinational gated read,
// whole array cleared asynchronously by rst.
module ram_mem
  import ram_mem_pkg::*;
#(
  parameter int unsigned W = RAM_W,
  parameter int unsigned L = RAM_L
) (
  input logic      clk,
  input logic      rst,
  ram_mem_if.slave bus
);

  localparam int unsigned AW = $clog2(L);

  logic [W-1:0] mem [L];
  logic         in_range_c;

  // Only non-power-of-2 depths can see addresses past the last word.
  if (L == (32'd1 << AW)) begin : g_full_range
    assign in_range_c = 1'b1;
  end else begin : g_partial_range
    assign in_range_c = (32'(bus.addr) < L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(L); i++) begin
        mem[i] <= '0;
      end
    end else if (bus.rw && in_range_c) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  // Output is driven low unless a valid, enabled read is in progress.
  always_comb begin
    bus.data_out = '0;
    if (bus.oe && !bus.rw && in_range_c) begin
      bus.data_out = mem[bus.addr];
    end
  end

endmodule : ram_mem

// File: tb/tb_ram_mem.sv
// Directed self-checking bench for ram_mem: default 16-word instance plus a
// 10-word instance for out-of-range addressing.
module tb_ram_mem;
  import ram_mem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ram_mem_if #(.W(RAM_W), .L(RAM_L)) bus16 ();
  ram_mem_if #(.W(RAM_W), .L(10))    bus10 ();

  ram_mem #(.W(RAM_W), .L(RAM_L)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  ram_mem #(.W(RAM_W), .L(10))    dut10 (.clk(clk), .rst(rst), .bus(bus10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr16(input logic [3:0] a, input word_t d);
    @(negedge clk);
    bus16.addr    = a;
    bus16.data_in = d;
    bus16.rw      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd16(input logic [3:0] a, input word_t exp, input string tag);
    bus16.rw   = 1'b0;
    bus16.oe   = 1'b1;
    bus16.addr = a;
    #1;
    check(tag, bus16.data_out, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus16.addr = '0; bus16.data_in = '0; bus16.rw = 1'b0; bus16.oe = 1'b0;
    bus10.addr = '0; bus10.data_in = '0; bus10.rw = 1'b0; bus10.oe = 1'b0;
    #1;
    check("oe_low_in_reset", bus16.data_out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cleared array reads zero everywhere
    for (int i = 0; i < 16; i++) begin
      rd16(4'(i), 32'h0, $sformatf("reset_rd_%0d", i));
    end

    // Back-to-back writes then zero-latency readback
    wr16(4'd0, 32'hFFFFFF8D);
    wr16(4'd1, 32'h00000021);
    wr16(4'd2, 32'h0000003A);
    wr16(4'd3, 32'h0000002F);
    wr16(4'd4, 32'h0000009F);
    rd16(4'd0, 32'hFFFFFF8D, "wb_rd_0");
    rd16(4'd1, 32'h00000021, "wb_rd_1");
    rd16(4'd2, 32'h0000003A, "wb_rd_2");
    rd16(4'd3, 32'h0000002F, "wb_rd_3");
    rd16(4'd4, 32'h0000009F, "wb_rd_4");
    for (int i = 5; i < 8; i++) begin
      rd16(4'(i), 32'h0, $sformatf("wb_unwritten_%0d", i));
    end

    // Program load and overwrite
    wr16(4'd8,  32'h00102283);
    wr16(4'hE,  32'h40A485B3);
    wr16(4'hF,  32'h00B02023);
    rd16(4'hE, 32'h40A485B3, "prog_rd_e");
    rd16(4'hF, 32'h00B02023, "prog_rd_f");
    rd16(4'd8, 32'h00102283, "prog_rd_8");
    wr16(4'hE,  32'h12345678);
    rd16(4'hE, 32'h12345678, "prog_overwrite_e");
    rd16(4'd0, 32'hFFFFFF8D, "prog_keep_0");

    // Output gating, all inside one low clock phase so rw=1 never meets an edge
    @(negedge clk);
    bus16.addr = 4'd1;
    bus16.rw   = 1'b0;
    bus16.oe   = 1'b0;
    #1 check("gate_oe0", bus16.data_out, 32'h0);
    bus16.rw = 1'b1;
    bus16.oe = 1'b1;
    #1 check("gate_rw1", bus16.data_out, 32'h0);
    bus16.rw = 1'b0;
    #1 check("gate_reopen", bus16.data_out, 32'h00000021);
    @(posedge clk); #1;
    check("gate_no_write", bus16.data_out, 32'h00000021);

    // Asynchronous reset between edges, then a blocked write
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1 check("async_rst_out", bus16.data_out, 32'h0);
    bus16.addr = 4'hF;
    #1 check("async_rst_f", bus16.data_out, 32'h0);
    @(negedge clk);
    bus16.addr    = 4'd2;
    bus16.data_in = 32'hDEADBEEF;
    bus16.rw      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus16.rw = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd16(4'(i), 32'h0, $sformatf("post_rst_rd_%0d", i));
    end

    // 10-word instance: address 12 is out of range, 9 is the last word
    @(negedge clk);
    bus10.addr    = 4'd12;
    bus10.data_in = 32'h0000AAAA;
    bus10.rw      = 1'b1;
    @(negedge clk);
    bus10.addr    = 4'd9;
    bus10.data_in = 32'h00005555;
    @(posedge clk); #1;
    bus10.rw   = 1'b0;
    bus10.oe   = 1'b1;
    bus10.addr = 4'd12;
    #1 check("l10_rd_12", bus10.data_out, 32'h0);
    bus10.addr = 4'd9;
    #1 check("l10_rd_9", bus10.data_out, 32'h00005555);
    for (int i = 0; i < 9; i++) begin
      bus10.addr = 4'(i);
      #1 check($sformatf("l10_rd_%0d", i), bus10.data_out, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_mem
